// File: rtl/stack_port.sv
// stack_port: turns core push/pop requests into stack-memory transactions.
// Full-descending stack: push pre-decrements sp then writes, pop reads then
// post-increments sp. Optional macro STACK_PEEK_EN enables op 2'b10 (peek),
// a top-of-stack read that leaves sp untouched.
module stack_port #(
    parameter int unsigned DATA_W      = 8,
    parameter logic [15:0] STACK_BASE  = 16'h1000,
    parameter logic [15:0] STACK_LIMIT = 16'h0F00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic [15:0]       sp_q,
    output logic              sp_d,
    output logic              sp_en,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] OpPush = 2'b00;
    localparam logic [1:0] OpPop  = 2'b01;
    localparam logic [1:0] OpPeek = 2'b10;

    typedef enum logic [2:0] {StIdle, StDec, StWr, StRd, StInc, StResp} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
`ifdef STACK_PEEK_EN
    logic              peek_q, peek_d;
`endif

    // State and transaction registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef STACK_PEEK_EN
            peek_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef STACK_PEEK_EN
            peek_q  <= peek_d;
`endif
        end
    end

    // Next-state decode and per-state strobes; all outputs idle by default.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
`ifdef STACK_PEEK_EN
        peek_d     = peek_q;
`endif
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        sp_en      = 1'b0;
        sp_d       = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    data_d  = req_data;
                    rdata_d = '0;
                    err_d   = 1'b0;
`ifdef STACK_PEEK_EN
                    peek_d  = (req_op == OpPeek);
`endif
                    unique case (req_op)
                        OpPush: begin
                            if (sp_q == STACK_LIMIT) begin
                                err_d   = 1'b1;
                                state_d = StResp;
                            end else begin
                                state_d = StDec;
                            end
                        end
`ifdef STACK_PEEK_EN
                        OpPop, OpPeek: begin
`else
                        OpPop: begin
`endif
                            if (sp_q == STACK_BASE) begin
                                err_d   = 1'b1;
                                state_d = StResp;
                            end else begin
                                state_d = StRd;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = StResp;
                        end
                    endcase
                end
            end
            StDec: begin
                sp_en   = 1'b1;
                sp_d    = 1'b1;
                state_d = StWr;
            end
            StWr: begin
                mem_addr  = sp_q;
                mem_wdata = data_q;
                mem_we    = 1'b1;
                if (mem_ready) begin
                    state_d = StResp;
                end
            end
            StRd: begin
                mem_addr = sp_q;
                mem_re   = 1'b1;
                if (mem_ready) begin
                    rdata_d = mem_rdata;
`ifdef STACK_PEEK_EN
                    state_d = peek_q ? StResp : StInc;
`else
                    state_d = StInc;
`endif
                end
            end
            StInc: begin
                sp_en   = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_data = rdata_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_stack_port.sv
// Bench for stack_port: models the sp block and data memory, predicts each
// response into a queue at request time and compares when the core takes it.
module tb_stack_port;

    localparam int unsigned DW    = 8;
    localparam logic [15:0] BASE  = 16'h1000;
    localparam logic [15:0] LIMIT = 16'h0F00;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_data;
    logic [15:0]   sp_q;
    logic          sp_d, sp_en;
    logic [15:0]   mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_re, mem_ready;

    logic          sp_load;
    logic [15:0]   sp_load_val;
    logic [7:0]    tbmem   [0:65535];
    logic [7:0]    exp_mem [0:65535];
    logic [15:0]   exp_sp;
    logic [8:0]    exp_q[$];

    int cnt_total, cnt_bad;
    int n_en, n_we, n_re;
    int s_en, s_we, s_re;

    stack_port #(.DATA_W(DW), .STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err),
        .sp_q(sp_q), .sp_d(sp_d), .sp_en(sp_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sp block model (reset to BASE, plus a bench-only preload)
    always @(posedge clk or posedge rst) begin
        if (rst) sp_q <= BASE;
        else if (sp_load) sp_q <= sp_load_val;
        else if (sp_en) sp_q <= sp_d ? sp_q - 16'd1 : sp_q + 16'd1;
    end

    // data memory model
    always @(posedge clk) begin
        if (!rst && mem_we && mem_ready) tbmem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = tbmem[mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cnt_total++;
        if (got !== exp) begin
            cnt_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // strobe counters and response scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (sp_en) n_en++;
            if (mem_we) n_we++;
            if (mem_re) n_re++;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check_val("resp_data", resp_data, e[7:0]);
                    check_val("resp_err", resp_err, e[8]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_req_ready"}, req_ready, 1);
        check_val({tag, "_resp_valid"}, resp_valid, 0);
        check_val({tag, "_resp_err"}, resp_err, 0);
        check_val({tag, "_resp_data"}, resp_data, 0);
        check_val({tag, "_sp_en"}, sp_en, 0);
        check_val({tag, "_sp_d"}, sp_d, 0);
        check_val({tag, "_mem_we"}, mem_we, 0);
        check_val({tag, "_mem_re"}, mem_re, 0);
        check_val({tag, "_mem_addr"}, mem_addr, 0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Drive one request (called #1 after a rising edge); returns in cycle 1.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int n;
        logic e_err;
        logic [7:0] e_dat;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check_val("req_ready_timeout", req_ready, 1);
            return;
        end
        e_err = 1'b0;
        e_dat = 8'h00;
        case (op)
            2'b00: if (exp_sp == LIMIT) e_err = 1'b1;
                   else begin exp_sp = exp_sp - 16'd1; exp_mem[exp_sp] = data; end
            2'b01: if (exp_sp == BASE) e_err = 1'b1;
                   else begin e_dat = exp_mem[exp_sp]; exp_sp = exp_sp + 16'd1; end
`ifdef STACK_PEEK_EN
            2'b10: if (exp_sp == BASE) e_err = 1'b1;
                   else e_dat = exp_mem[exp_sp];
`endif
            default: e_err = 1'b1;
        endcase
        exp_q.push_back({e_err, e_dat});
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain", exp_q.size(), 0);
        exp_q.delete();
        check_val("sp_after", sp_q, exp_sp);
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [7:0] data);
        send(op, data);
        wait_drain();
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("resp_valid_wait", resp_valid, 1);
    endtask

    task automatic load_sp(input logic [15:0] v);
        sp_load = 1'b1;
        sp_load_val = v;
        @(posedge clk); #1;
        sp_load = 1'b0;
        exp_sp = v;
    endtask

    task automatic snap();
        s_en = n_en; s_we = n_we; s_re = n_re;
    endtask

    task automatic pulse_delta(input string tag, input int en, input int we, input int re);
        check_val({tag, "_sp_en_pulses"}, n_en - s_en, en);
        check_val({tag, "_mem_we_pulses"}, n_we - s_we, we);
        check_val({tag, "_mem_re_pulses"}, n_re - s_re, re);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        cnt_total = 0; cnt_bad = 0;
        n_en = 0; n_we = 0; n_re = 0;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0;
        resp_ready = 1'b1; mem_ready = 1'b1; sp_load = 1'b0; sp_load_val = '0;
        exp_sp = BASE;
        #2;
        check_reset_outs("por");
        #20 rst = 1'b0;
        @(posedge clk); #1;
        check_val("idle_req_ready", req_ready, 1);

        // underflow at empty stack
        snap();
        do_txn(2'b01, 8'h00);
        pulse_delta("underflow", 0, 0, 0);

        // push A5 cycle by cycle
        send(2'b00, 8'hA5);
        check_val("push_c1_sp_en", sp_en, 1);
        check_val("push_c1_sp_d", sp_d, 1);
        check_val("push_c1_req_ready", req_ready, 0);
        @(posedge clk); #1;
        check_val("push_c2_we", mem_we, 1);
        check_val("push_c2_addr", mem_addr, 16'h0FFF);
        check_val("push_c2_wdata", mem_wdata, 8'hA5);
        check_val("push_c2_sp_en", sp_en, 0);
        @(posedge clk); #1;
        check_val("push_c3_resp_valid", resp_valid, 1);
        check_val("push_c3_resp_err", resp_err, 0);
        wait_drain();

        // pop A5 cycle by cycle
        send(2'b01, 8'h00);
        check_val("pop_c1_re", mem_re, 1);
        check_val("pop_c1_addr", mem_addr, 16'h0FFF);
        check_val("pop_c1_sp_en", sp_en, 0);
        @(posedge clk); #1;
        check_val("pop_c2_sp_en", sp_en, 1);
        check_val("pop_c2_sp_d", sp_d, 0);
        check_val("pop_c2_re", mem_re, 0);
        @(posedge clk); #1;
        check_val("pop_c3_resp_valid", resp_valid, 1);
        check_val("pop_c3_resp_data", resp_data, 8'hA5);
        wait_drain();

        // push with memory stalled three cycles
        mem_ready = 1'b0;
        send(2'b00, 8'h3C);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check_val("stall_we", mem_we, 1);
            check_val("stall_addr", mem_addr, 16'h0FFF);
            check_val("stall_wdata", mem_wdata, 8'h3C);
            check_val("stall_req_ready", req_ready, 0);
            check_val("stall_resp_valid", resp_valid, 0);
            if (k == 3) mem_ready = 1'b1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        check_val("stall_resp_after", resp_valid, 1);
        wait_drain();

        // response held by the core; a new request must not be accepted
        resp_ready = 1'b0;
        send(2'b01, 8'h00);
        wait_resp();
        snap();
        req_valid = 1'b1; req_op = 2'b00; req_data = 8'h77;
        for (int k = 0; k < 2; k++) begin
            check_val("hold_resp_valid", resp_valid, 1);
            check_val("hold_resp_data", resp_data, 8'h3C);
            check_val("hold_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        pulse_delta("hold", 0, 0, 0);
        resp_ready = 1'b1;
        wait_drain();

        // several data patterns, LIFO order, peek
        for (int i = 0; i < 4; i++) do_txn(2'b00, 8'(8'h11 * (i + 1)));
        do_txn(2'b01, 8'h00);
        do_txn(2'b01, 8'h00);
        snap();
        do_txn(2'b10, 8'h00);
`ifdef STACK_PEEK_EN
        pulse_delta("peek", 0, 0, 1);
`else
        pulse_delta("peek", 0, 0, 0);
`endif
        do_txn(2'b01, 8'h00);
        do_txn(2'b01, 8'h00);

        // reserved op
        snap();
        do_txn(2'b11, 8'h5A);
        pulse_delta("illegal", 0, 0, 0);

        // last free slot, then overflow
        load_sp(16'h0F01);
        do_txn(2'b00, 8'hE7);
        snap();
        do_txn(2'b00, 8'h18);
        pulse_delta("overflow", 0, 0, 0);
        do_txn(2'b01, 8'h00);

        // reset while in WR
        mem_ready = 1'b0;
        send(2'b00, 8'h99);
        @(posedge clk); #1;
        check_val("wr_before_rst", mem_we, 1);
        pulse_reset();
        check_reset_outs("rst_wr");
        exp_q.delete();
        exp_sp = BASE;
        mem_ready = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_wr_release_ready", req_ready, 1);
        check_val("rst_wr_sp", sp_q, BASE);

        // reset while in RESP
        do_txn(2'b00, 8'hC3);
        resp_ready = 1'b0;
        send(2'b01, 8'h00);
        wait_resp();
        check_val("resp_before_rst", resp_data, 8'hC3);
        pulse_reset();
        check_reset_outs("rst_resp");
        exp_q.delete();
        exp_sp = BASE;
        resp_ready = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_resp_release_ready", req_ready, 1);
        do_txn(2'b00, 8'h6B);
        do_txn(2'b01, 8'h00);

        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $finish;
    end

endmodule

// File: doc/stack_port.md
Name: stack_port

Overview:
- Load-store-unit sequencer that turns core push/pop requests into stack-memory transactions.
- Drives the `sp` stack-pointer block through its `d`/`en` control inputs and consumes its `q` output as the memory address.
- Full-descending stack: push pre-decrements `sp` then writes; pop reads then post-increments `sp`.
- Sits between the core request interface and the data-memory port.

Parameters:
- DATA_W, 8, memory/request data width.
- STACK_BASE, 16'h1000, `sp` value when the stack is empty. The system resets `sp` to this value.
- STACK_LIMIT, 16'h0F00, `sp` value when the stack is full.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  request accepted when high together with req_valid
- req_op  in  2  00 push, 01 pop, 10 peek (peek only with the optional feature), 11 reserved
- req_data  in  DATA_W  push data
- resp_valid  out  1  response present
- resp_ready  in  1  core takes the response
- resp_data  out  DATA_W  pop/peek data; 0 for push
- resp_err  out  1  overflow, underflow or illegal op
- sp_q  in  16  current stack pointer (`sp.q`)
- sp_d  out  1  to `sp.d`: 1 = decrement, 0 = increment
- sp_en  out  1  to `sp.en`: one-cycle pointer update
- mem_addr  out  16  memory address
- mem_wdata  out  DATA_W  write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  DATA_W  read data, valid when mem_ready is high
- mem_ready  in  1  memory completes the current access this cycle

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): state goes to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_data=0.
  - sp_en=0, sp_d=0.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - Any in-flight transaction is abandoned.
- States: IDLE, DEC, WR, RD, INC, RESP.
- IDLE: req_ready=1. On req_valid, latch req_op and req_data, then:
  - push, sp_q==STACK_LIMIT → RESP with resp_err=1; `sp` untouched.
  - pop/peek, sp_q==STACK_BASE → RESP with resp_err=1.
  - op 11, or op 10 without the feature → RESP with resp_err=1.
  - push otherwise → DEC.
  - pop/peek otherwise → RD.
- DEC: sp_en=1, sp_d=1 for exactly one cycle → WR.
- WR:
  - mem_addr=sp_q (already decremented).
  - mem_wdata=latched data; mem_we=1.
  - Hold all three until mem_ready, then → RESP.
- RD:
  - mem_addr=sp_q, mem_re=1; hold until mem_ready.
  - On mem_ready, capture mem_rdata into resp_data.
  - Then pop → INC, peek → RESP.
- INC: sp_en=1, sp_d=0 for exactly one cycle → RESP.
- RESP: resp_valid=1; resp_data and resp_err stable. On resp_ready → IDLE; resp_valid, resp_err and resp_data clear.
- req_ready is 0 in every state except IDLE. Only one transaction is in flight.
- sp_en is high only in DEC and INC, at most one cycle per transaction. `sp` never moves on an error.
- Latency with mem_ready tied high and resp_ready high (request accepted in cycle 0):
  - push: resp_valid in cycle 3.
  - pop: resp_valid in cycle 3.
  - peek: resp_valid in cycle 2.
- Boundaries:
  - 16-bit address arithmetic wraps modulo 2^16 inside `sp`. The block only compares sp_q against the parameters for equality.
  - A request arriving while req_ready=0 is ignored; the core holds it.
  - resp_ready high outside RESP has no effect.

Optional Feature:
- STACK_PEEK_EN defined: op 10 reads the top of stack (mem_addr=sp_q) without issuing sp_en. Underflow check identical to pop.
- Undefined: op 10 returns resp_err=1 with no memory or `sp` activity. The RD→RESP peek path is not built.

Test Plan:
- Push 8'hA5 with sp_q=16'h1000 (ready tied high) → cycle 1: sp_en=1, sp_d=1. Cycle 2: mem_we=1, mem_addr=16'h0FFF, mem_wdata=8'hA5. Cycle 3: resp_valid=1, resp_err=0. Final sp_q=16'h0FFF.
- Pop after that push with mem_rdata=8'hA5 → mem_re=1 at mem_addr=16'h0FFF, then sp_en=1, sp_d=0. resp_data=8'hA5, resp_err=0, sp_q=16'h1000.
- Pop at sp_q=16'h1000 → resp_err=1 with no sp_en/mem_re pulse. Push at sp_q=16'h0F00 → resp_err=1 with no sp_en/mem_we pulse.
- mem_ready held low 3 cycles during a push → mem_we, mem_addr and mem_wdata stable for 4 cycles. req_ready=0 throughout. resp_valid follows 1 cycle after mem_ready.
- resp_ready held low 2 cycles → resp_valid and resp_data held. A new request is not accepted until after the handshake.
- rst pulsed in WR, and separately in RESP → all outputs return to reset values immediately. req_ready=1 after release. Peek with STACK_PEEK_EN at sp_q=16'h0FFF returns data with no sp_en; without the macro it returns resp_err=1.
